// File: rtl/nr_pkg.sv
// Shared types and constants for the Newton-Raphson sigmoid reciprocal refinement.
// Q4.16 data: 4 integer bits, 16 fractional bits, unsigned.
package nr_pkg;

  localparam int W        = 20;
  localparam int FRAC     = 16;
  localparam int MAX_ITER = 4;
  localparam int CNT_W    = 3;

  typedef logic [W-1:0] q4_16_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    HOLD = 2'd2
  } nr_state_e;

  localparam q4_16_t ONE_Q = 20'h10000;

  // Requested iteration counts above MAX_ITER are silently limited to it.
  function automatic logic [CNT_W-1:0] clamp_iter(input logic [CNT_W-1:0] iter);
    if (iter > CNT_W'(MAX_ITER)) begin
      return CNT_W'(MAX_ITER);
    end
    return iter;
  endfunction

endpackage

// File: rtl/nr_step.sv
// One combinational Newton-Raphson step for the reciprocal of (1 + e):
//   y' = 2y - y^2 * (1 + e), computed exactly on wide unsigned products.
// With NR_SAT_EN defined, a negative step result is forced to 0 and flagged
// through sat; otherwise the wrapped slice passes through and sat stays 0.
module nr_step
  import nr_pkg::*;
(
  input  q4_16_t y,
  input  q4_16_t e,
  output q4_16_t result,
  output logic   sat
);

  logic [2*W-1:0] sq;
  logic [W:0]     d;
  logic [3*W-1:0] t;
  logic [3*W-1:0] y_shift;
  logic [3*W-1:0] r;
  q4_16_t         slice;
  logic           step_unused;

  // Exact products: y^2 is Q8.32, times (1+e) gives Q.48, and 2y is lined up
  // with that Q.48 scaling before the subtraction wraps in 3W bits.
  always_comb begin
    sq      = (2*W)'(y) * (2*W)'(y);
    d       = (W+1)'(ONE_Q) + (W+1)'(e);
    t       = (3*W)'(sq) * (3*W)'(d);
    y_shift = (3*W)'(y) << (2*FRAC + 1);
    r       = y_shift - t;
  end

  assign slice = r[W+2*FRAC-1 : 2*FRAC];

`ifdef NR_SAT_EN
  assign result = r[3*W-1] ? '0 : slice;
  assign sat    = r[3*W-1];
`else
  assign result = slice;
  assign sat    = 1'b0;
`endif

  // Truncated fraction bits and the top guard bits are dropped by design.
  assign step_unused = ^{r[3*W-1 : W+2*FRAC], r[2*FRAC-1:0]};

endmodule

// File: rtl/nr_iter_seq.sv
// Iterative Newton-Raphson refinement sequencer for the sigmoid reciprocal stage.
// Takes a PWL estimate y0 and e^-x, applies a single shared NR step for up to
// MAX_ITER cycles, then presents the refined Q4.16 result on a valid/ready port.
// Optional feature macro: NR_SAT_EN (clamp negative step results to 0, report out_sat).
module nr_iter_seq
  import nr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  q4_16_t           in_pwl,
  input  q4_16_t           in_exp,
  input  logic [CNT_W-1:0] in_iter,
  output logic             out_valid,
  input  logic             out_ready,
  output q4_16_t           out_y,
  output logic             out_sat,
  output logic             busy
);

  nr_state_e        state;
  q4_16_t           y_reg;
  q4_16_t           e_reg;
  logic [CNT_W-1:0] cnt;
  logic             sat_reg;

  q4_16_t           step_y;
  logic             step_sat;
  logic [CNT_W-1:0] iter_clamped;

  assign iter_clamped = clamp_iter(in_iter);

  nr_step u_step (
    .y      (y_reg),
    .e      (e_reg),
    .result (step_y),
    .sat    (step_sat)
  );

  // Sequencer: capture in IDLE, refine once per cycle in ITER, present in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y_reg     <= '0;
      e_reg     <= '0;
      cnt       <= '0;
      sat_reg   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_reg    <= in_pwl;
            e_reg    <= in_exp;
            cnt      <= iter_clamped;
            sat_reg  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (iter_clamped == '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          y_reg   <= step_y;
          sat_reg <= sat_reg | step_sat;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_y   = y_reg;
  assign out_sat = sat_reg;

endmodule
